// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg
// Shared definitions for the pipeline hazard/stall control logic.
//   ctrl_state_t        : control FSM states (RUN, MD_BUSY)
//   REG_ADDR_W_DEFAULT  : default register-file address width
//   ZERO_REG            : architectural zero register index (never a hazard source)
//   STALL_CNT_W         : width of the saturating stall-cycle counter
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W_DEFAULT = 5;
  localparam int ZERO_REG           = 0;
  localparam int STALL_CNT_W        = 16;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } ctrl_state_t;

endpackage

// File: rtl/stall_timer.sv
// stall_timer
// Loadable down-counter that times the EX occupancy of a mult/div.
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset (count -> 0)
//   load       in   load count with load_value at the next edge
//   en         in   decrement at the next edge (stops at 0)
//   load_value in   W  value loaded when load=1
//   tc         out  terminal count: count==1, i.e. the next edge is the last
module stall_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_value,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign tc = (count_reg == W'(1));

endmodule

// File: rtl/hazard_control_unit.sv
// hazard_control_unit
// Pipeline control beside the ID stage: load-use stall, mult/div occupancy
// hold, taken-branch flush of IF/ID, and a saturating stall-cycle counter.
//   Clk            in   clock, rising edge
//   Reset          in   asynchronous active-low reset; all outputs 0 while low
//   ID_Rs, ID_Rt   in   source register fields of the ID instruction
//   ID_UsesRs/Rt   in   ID instruction really reads Rs / Rt
//   ID_MulDiv      in   ID instruction is a mult/div
//   ID_BranchTaken in   branch/jump in ID resolved taken
//   EX_MemRead     in   EX instruction is a load
//   EX_Rt          in   destination register of the load in EX
//   PC_Hold        out  PC does not update
//   IF_ID_Write    out  IF/ID holds (hold polarity)
//   IF_ID_Flush    out  IF/ID loads a NOP
//   ID_EX_Bubble   out  ID/EX control fields load zero
//   ID_EX_Hold     out  ID/EX holds its contents
//   Busy           out  FSM is in MD_BUSY
//   StallCount     out  cycles with PC_Hold=1, saturating at all-ones
module hazard_control_unit
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W    = REG_ADDR_W_DEFAULT,
  parameter int MULDIV_CYCLES = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [REG_ADDR_W-1:0]  ID_Rs,
  input  logic [REG_ADDR_W-1:0]  ID_Rt,
  input  logic                   ID_UsesRs,
  input  logic                   ID_UsesRt,
  input  logic                   ID_MulDiv,
  input  logic                   ID_BranchTaken,
  input  logic                   EX_MemRead,
  input  logic [REG_ADDR_W-1:0]  EX_Rt,
  output logic                   PC_Hold,
  output logic                   IF_ID_Write,
  output logic                   IF_ID_Flush,
  output logic                   ID_EX_Bubble,
  output logic                   ID_EX_Hold,
  output logic                   Busy,
  output logic [STALL_CNT_W-1:0] StallCount
);

  localparam int              TMR_W   = $clog2(MULDIV_CYCLES) + 1;
  localparam logic [TMR_W-1:0] MD_LOAD = TMR_W'(MULDIV_CYCLES - 1);

  ctrl_state_t            state_reg, state_next;
  logic                   load_use;
  logic                   md_start;
  logic                   tmr_tc;
  logic                   busy;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  assign busy = (state_reg == MD_BUSY);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    load_use     = 1'b0;
    md_start     = 1'b0;
    PC_Hold      = 1'b0;
    IF_ID_Write  = 1'b0;
    IF_ID_Flush  = 1'b0;
    ID_EX_Bubble = 1'b0;
    ID_EX_Hold   = 1'b0;
    case (state_reg)
      RUN: begin
        load_use = EX_MemRead
                && (EX_Rt != REG_ADDR_W'(ZERO_REG))
                && ((ID_UsesRs && (ID_Rs == EX_Rt)) ||
                    (ID_UsesRt && (ID_Rt == EX_Rt)));
        PC_Hold      = load_use;
        IF_ID_Write  = load_use;
        ID_EX_Bubble = load_use;
        // A held ID re-presents the branch after the stall, so suppress it now.
        IF_ID_Flush  = ID_BranchTaken && !load_use;
        if (ID_MulDiv && !load_use) begin
          md_start   = 1'b1;
          state_next = MD_BUSY;
        end
      end
      MD_BUSY: begin
        PC_Hold     = 1'b1;
        IF_ID_Write = 1'b1;
        ID_EX_Hold  = 1'b1;
        if (tmr_tc) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
    // Combinational outputs follow live inputs, so they must be masked
    // explicitly while reset is held.
    if (!Reset) begin
      PC_Hold      = 1'b0;
      IF_ID_Write  = 1'b0;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      ID_EX_Hold   = 1'b0;
    end
  end

  assign Busy = busy;

  stall_timer #(
    .W (TMR_W)
  ) u_stall_timer (
    .clk        (Clk),
    .rst_n      (Reset),
    .load       (md_start),
    .en         (busy),
    .load_value (MD_LOAD),
    .tc         (tmr_tc)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt_reg <= '0;
    end else if (PC_Hold && (stall_cnt_reg != '1)) begin
      stall_cnt_reg <= stall_cnt_reg + STALL_CNT_W'(1);
    end
  end

  assign StallCount = stall_cnt_reg;

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline control block for the five-stage datapath: detects load-use hazards and multi-cycle multiply/divide occupancy, and resolves taken branches in ID. It drives the hold, flush and bubble controls of the PC register, the IF/ID pipeline register and the ID/EX pipeline register. A saturating stall counter supports performance measurement. It sits beside the ID stage and consumes decoded register fields from ID and EX.

## Interface
- REG_ADDR_W, 5, register-file address width
- MULDIV_CYCLES, 4, EX occupancy of a mult/div instruction in cycles; must be at least 2
- Clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-low reset
- ID_Rs, ID_Rt  in  REG_ADDR_W  source register fields of the instruction in ID
- ID_UsesRs, ID_UsesRt  in  1  the ID instruction actually reads Rs / Rt
- ID_MulDiv  in  1  the ID instruction is a mult/div
- ID_BranchTaken  in  1  branch/jump in ID resolved taken this cycle
- EX_MemRead  in  1  the instruction in EX is a load
- EX_Rt  in  REG_ADDR_W  destination register of the load in EX
- PC_Hold  out  1  1 = PC does not update
- IF_ID_Write  out  1  1 = IF/ID register holds its contents (hold polarity, matches IF/ID register)
- IF_ID_Flush  out  1  1 = IF/ID loads zero (NOP) at the next edge
- ID_EX_Bubble  out  1  1 = ID/EX control fields load zero
- ID_EX_Hold  out  1  1 = ID/EX register holds its contents
- Busy  out  1  FSM is in MD_BUSY
- StallCount  out  16  count of cycles with PC_Hold=1, saturating

## Operation
- FSM states:
  - RUN: reset state.
  - MD_BUSY: entered from RUN when ID_MulDiv=1 and there is no load-use hazard. The entry edge loads the internal counter with MULDIV_CYCLES-1.
- Load-use hazard, evaluated only in RUN: EX_MemRead and EX_Rt≠0 and ((ID_UsesRs and ID_Rs==EX_Rt) or (ID_UsesRt and ID_Rt==EX_Rt)).
  - Response, same cycle: PC_Hold=1, IF_ID_Write=1, ID_EX_Bubble=1.
  - The bubble clears EX_MemRead at the next edge, so the stall lasts exactly 1 cycle.
- MD_BUSY:
  - Outputs: PC_Hold=1, IF_ID_Write=1, ID_EX_Hold=1, ID_EX_Bubble=0, IF_ID_Flush=0.
  - The counter decrements each cycle. When the counter equals 1, the next edge returns the FSM to RUN.
  - All ID and EX inputs are ignored.
- Branch, RUN only: ID_BranchTaken=1 with no load-use hazard gives IF_ID_Flush=1 for that cycle.
  - If a hazard is present, the flush is suppressed and the branch is re-evaluated after the stall, since ID is held.
  - A branch with ID_MulDiv=1 simultaneously is not possible, because decode makes them exclusive; if both are asserted, the flush takes effect and MD_BUSY is still entered.
- Priority: MD_BUSY > load-use > branch flush.
- Register 0 never causes a hazard.
- StallCount: increments on each edge where PC_Hold=1 and holds at 16'hFFFF.

## Timing
- Hazard, flush and bubble outputs are combinational from the inputs and the state, with zero latency, valid before the same rising edge.
- Busy, ID_EX_Hold and the MD_BUSY outputs are registered (Moore).
- A mult/div accepted at edge N keeps the pipeline held for edges N+1 through N+MULDIV_CYCLES-1; RUN resumes in the cycle after edge N+MULDIV_CYCLES-1.
  - Total stall is MULDIV_CYCLES-1 cycles.
- Reset low, any time including mid-MD_BUSY:
  - Immediately: state=RUN, counter=0, StallCount=0.
  - All outputs are forced 0 while Reset=0.
- First rising edge after Reset goes high: normal RUN evaluation.
- A load-use hazard present in the last MD_BUSY cycle is evaluated in the first RUN cycle.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - state enumeration (RUN, MD_BUSY);
  - REG_ADDR_W default;
  - ZERO_REG constant;
  - STALL_CNT_W=16.
- One sub-module, stall_timer: a loadable down-counter with a terminal-count flag, width $clog2(MULDIV_CYCLES)+1.
- Hazard comparison and the StallCount saturating counter stay in the top module.

## Test plan
- Load-use: EX_MemRead=1, EX_Rt=8, ID_Rs=8, ID_UsesRs=1 -> PC_Hold=IF_ID_Write=ID_EX_Bubble=1 for one cycle. Then EX_MemRead=0 -> all outputs 0 and StallCount=1.
- Register zero and unused operands:
  - EX_Rt=0 with ID_Rs=0 -> no stall.
  - EX_Rt=9, ID_Rt=9, ID_UsesRt=0 -> no stall.
- Mult/div, MULDIV_CYCLES=4: ID_MulDiv=1 in RUN -> Busy, PC_Hold and ID_EX_Hold high for exactly 3 cycles, then RUN.
  - A load-use pattern applied during MD_BUSY gives no bubble.
- Branch: ID_BranchTaken=1 with no hazard -> IF_ID_Flush=1 for one cycle.
  - Same with a load-use hazard -> flush=0 and stall=1. In the next cycle the branch is still asserted -> flush=1.
- Reset mid-MD_BUSY: Reset=0 after 1 busy cycle -> Busy=0 and StallCount=0 asynchronously, with no glitch on release.
  - Separately, force 70000 stall cycles -> StallCount=16'hFFFF.
